// File: rtl/fifo_ctrl_pkg.sv
// Shared types and elaboration helpers for the flexible FIFO controller.
// Op encoding matches the {wr, rd} request pair.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        READ       = 2'b01,
        WRITE      = 2'b10,
        READ_WRITE = 2'b11
    } fifo_op_t;

    // Thresholds must lie where the flags can both assert and deassert.
    function automatic bit levels_legal(input int addr_w, input int af_level, input int ae_level);
        int depth;
        depth = 1 << addr_w;
        return (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping ADDR_W-bit pointer; clr has priority over inc, both take effect on the next edge.
// Wraps DEPTH-1 -> 0 by natural binary overflow.
module fifo_ptr #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl_flex.sv
// FIFO pointer/occupancy controller for an external 2**ADDR_W-entry register file.
// Enables are combinational; count and flags update on the accepting edge. Full rejects writes unless a read frees a slot.
module fifo_ctrl_flex
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              flush,
    input  logic              wr,
    input  logic              rd,
    input  logic              err_clr,
    output logic              w_en,
    output logic              r_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LEVEL[ADDR_W:0];

    if (!levels_legal(ADDR_W, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("fifo_ctrl_flex: AF_LEVEL/AE_LEVEL out of range for ADDR_W");
    end

    fifo_op_t        op;
    logic [ADDR_W:0] count_nxt;
    logic            ovf_set;
    logic            unf_set;

    assign op = fifo_op_t'({wr, rd});

    // No fall-through: a read is judged on current occupancy only.
    always_comb begin
        w_en = 1'b0;
        r_en = 1'b0;
        unique case (op)
            IDLE: ;
            READ:  r_en = ~empty;
            WRITE: w_en = ~full;
            READ_WRITE: begin
                r_en = ~empty;
                w_en = ~full | ~empty;
            end
        endcase
        if (flush) begin
            w_en = 1'b0;
            r_en = 1'b0;
        end
    end

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (w_en && !r_en) begin
            count_nxt = count + 1'b1;
        end else if (r_en && !w_en) begin
            count_nxt = count - 1'b1;
        end
    end

    assign ovf_set = wr & full & ~r_en & ~flush;
    assign unf_set = rd & empty & ~flush;

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (Reset_n),
        .clr   (flush),
        .inc   (w_en),
        .ptr   (w_addr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (Reset_n),
        .clr   (flush),
        .inc   (r_en),
        .ptr   (r_addr)
    );

    // Flags derive from count_nxt so they line up with count, not a cycle behind.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= ovf_set | (overflow & ~err_clr);
            underflow    <= unf_set | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_flex.sv
// Bench for fifo_ctrl_flex: directed boundary scenarios then biased random traffic,
// all checked against an occupancy/pointer reference model.
module tb_fifo_ctrl_flex;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic          flush, wr, rd, err_clr;
    logic          w_en, r_en;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_cnt, m_wp, m_rp;
    bit m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_ctrl_flex #(.ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .flush        (flush),
        .wr           (wr),
        .rd           (rd),
        .err_clr      (err_clr),
        .w_en         (w_en),
        .r_en         (r_en),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"},  32'(count), 32'(m_cnt));
        chk({tag, ".full"},   32'(full), 32'(m_cnt == DEPTH));
        chk({tag, ".empty"},  32'(empty), 32'(m_cnt == 0));
        chk({tag, ".af"},     32'(almost_full), 32'(m_cnt >= AF));
        chk({tag, ".ae"},     32'(almost_empty), 32'(m_cnt <= AE));
        chk({tag, ".w_addr"}, 32'(w_addr), 32'(m_wp));
        chk({tag, ".r_addr"}, 32'(r_addr), 32'(m_rp));
        chk({tag, ".ovf"},    32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"},    32'(underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit w, input bit r, input bit f, input bit c);
        bit exp_r, exp_w, ovf_set, unf_set;
        wr = w; rd = r; flush = f; err_clr = c;
        exp_r = r && (m_cnt > 0) && !f;
        exp_w = w && ((m_cnt < DEPTH) || exp_r) && !f;
        #1;
        chk("w_en", 32'(w_en), 32'(exp_w));
        chk("r_en", 32'(r_en), 32'(exp_r));
        @(posedge clk);
        ovf_set = w && (m_cnt == DEPTH) && !exp_r && !f;
        unf_set = r && (m_cnt == 0) && !f;
        m_ovf = ovf_set || (m_ovf && !c);
        m_unf = unf_set || (m_unf && !c);
        if (f) begin
            m_cnt = 0; m_wp = 0; m_rp = 0;
        end else begin
            m_cnt = m_cnt + int'(exp_w) - int'(exp_r);
            m_wp  = (m_wp + int'(exp_w)) % DEPTH;
            m_rp  = (m_rp + int'(exp_r)) % DEPTH;
        end
        @(negedge clk);
        wr = 0; rd = 0; flush = 0; err_clr = 0;
        check_state("st");
    endtask

    // Asserts reset mid-cycle and checks outputs before any clock edge arrives.
    task automatic do_reset();
        Reset_n = 1'b0;
        #2;
        model_reset();
        check_state("rst");
        @(negedge clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        int pw, pr;
        Reset_n = 1'b1; flush = 0; wr = 0; rd = 0; err_clr = 0;
        @(negedge clk);
        do_reset();

        // Fill to full, watching almost_full switch at AF
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, 0, 0);
            if (i == AF - 1) chk("af_before_level", 32'(almost_full), 32'd0);
            if (i == AF)     chk("af_at_level", 32'(almost_full), 32'd1);
        end
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.w_addr_wrap", 32'(w_addr), 32'd0);
        chk("fill.ovf", 32'(overflow), 32'd0);

        // Simultaneous read/write while full
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("full_rw.count", 32'(count), 32'd16);
        chk("full_rw.w_addr", 32'(w_addr), 32'd5);
        chk("full_rw.r_addr", 32'(r_addr), 32'd5);

        // Overflow is sticky across flush, cleared only by err_clr
        step(1, 0, 0, 0);
        chk("ovf.set", 32'(overflow), 32'd1);
        step(0, 0, 1, 0);
        chk("ovf.after_flush", 32'(overflow), 32'd1);
        chk("ovf.flush_count", 32'(count), 32'd0);
        step(0, 0, 0, 1);
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // Empty with wr&rd: write only, underflow set
        step(1, 1, 0, 0);
        chk("empty_rw.count", 32'(count), 32'd1);
        chk("empty_rw.unf", 32'(underflow), 32'd1);
        // Set and clear together: set wins
        step(0, 0, 1, 0);
        step(0, 1, 0, 1);
        chk("unf.set_wins", 32'(underflow), 32'd1);
        step(0, 0, 0, 1);
        chk("unf.cleared", 32'(underflow), 32'd0);

        // Flush at count 9 with wr&rd presented
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
        chk("pre_flush.count", 32'(count), 32'd9);
        step(1, 1, 1, 0);
        chk("flush9.count", 32'(count), 32'd0);
        chk("flush9.ae", 32'(almost_empty), 32'd1);

        // Async reset at count 7
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        do_reset();
        chk("post_rst.w_addr", 32'(w_addr), 32'd0);
        step(1, 0, 0, 0);
        chk("post_rst.count", 32'(count), 32'd1);

        // Biased random traffic segments
        for (int seg = 0; seg < 12; seg++) begin
            pw = $urandom_range(90, 10);
            pr = $urandom_range(90, 10);
            for (int n = 0; n < 200; n++) begin
                step($urandom_range(99) < pw, $urandom_range(99) < pr,
                     $urandom_range(99) < 2, $urandom_range(99) < 5);
            end
            if (seg % 4 == 3) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl_flex.md
Name: fifo_ctrl_flex

Overview:
Parametrised next-generation FIFO control unit for the UART TX/RX buffers. It keeps the read/write pointers and status flags for an external 2**ADDR_W-entry register file. Compared with the previous controller it adds:
- an occupancy counter and programmable almost-full/almost-empty flags;
- correct simultaneous read/write at the full and empty boundaries;
- synchronous flush;
- sticky overflow/underflow error flags.

Parameters:
ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries (16 by default)
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (range 1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (range 0..DEPTH-1)

Ports:
clk  in  1  single clock, rising edge
Reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pointers and count
wr  in  1  write request
rd  in  1  read request
err_clr  in  1  clears sticky overflow/underflow
w_en  out  1  write accepted this cycle (combinational; drives RAM write enable)
r_en  out  1  read accepted this cycle (combinational)
w_addr  out  ADDR_W  current write pointer
r_addr  out  ADDR_W  current read pointer
count  out  ADDR_W+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow  out  1  sticky: set by wr while full and no read accepted
underflow  out  1  sticky: set by rd while empty

Behaviour:
- Clock and reset: one clock `clk`. Reset `Reset_n` is asynchronous and active-low.
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (given AF_LEVEL >= 1), overflow 0, underflow 0.
- Acceptance (combinational, same cycle):
  - r_en = rd & ~empty
  - w_en = wr & (~full | r_en)
  - A write to a full FIFO is accepted only when a read is accepted in the same cycle.
  - A read of an empty FIFO is never accepted, even if a write is accepted in the same cycle (no fall-through).
- Pointers:
  - w_addr increments on w_en; r_addr increments on r_en.
  - Both wrap modulo DEPTH naturally (DEPTH-1 -> 0).
  - Addresses are presented in the same cycle as the enables; the RAM writes at w_addr on the clock edge.
- Count:
  - +1 on w_en only, -1 on r_en only, unchanged when both or neither.
  - Width ADDR_W+1, so DEPTH is representable.
  - Never exceeds DEPTH and never underflows 0.
- Flags:
  - All flags are registered and computed from the next-state count.
  - They are therefore valid in the cycle after the enabling edge, with no extra latency relative to count.
- Flush:
  - Highest priority over wr/rd.
  - Next state: pointers 0, count 0, flags as at reset.
  - w_en and r_en are forced 0 during flush.
  - Does not clear overflow/underflow.
  - Requests presented in a flush cycle count as rejected but do not set error flags.
- Errors:
  - overflow sets next edge when wr & full & ~r_en & ~flush.
  - underflow sets next edge when rd & empty & ~flush.
  - Both hold until err_clr. When set and clear coincide in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Outputs are valid from the first edge after Reset_n deasserts.
- No state machine beyond the pointer/count registers. Op decode uses the package enum {IDLE, READ, WRITE, READ_WRITE} on {wr, rd}.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - typedef enum logic [1:0] fifo_op_t (IDLE = 2'b00, READ = 2'b01, WRITE = 2'b10, READ_WRITE = 2'b11);
  - a function for threshold legality checking, used by an elaboration-time assertion on AF_LEVEL/AE_LEVEL.
- One sub-module, fifo_ptr:
  - ADDR_W-wide wrap counter with inc and clr inputs and asynchronous active-low reset;
  - instantiated twice (write and read pointer).
- count and the flag registers stay in the top level.

Test Plan:
- Reset then 16 writes, no reads -> count 16, full 1 after the 16th edge, almost_full 1 from count 14, w_addr wraps to 0, overflow 0.
- FIFO full, wr=1 rd=1 for 5 cycles -> w_en=r_en=1 each cycle, count stays 16, full stays 1, pointers advance by 5, overflow 0.
- FIFO empty, wr=1 rd=1 -> w_en 1, r_en 0, count 1, empty 0 next cycle, underflow 1; err_clr=1 next cycle -> underflow 0.
- FIFO full, wr=1 rd=0 -> w_en 0, count 16, overflow 1; overflow stays set through a subsequent flush and clears only on err_clr.
- Count 9, flush=1 with wr=1 rd=1 -> w_en=r_en=0, next cycle count 0, empty 1, almost_empty 1, w_addr=r_addr=0, error flags unchanged.
- Count 7, Reset_n low between edges -> outputs at reset values immediately, without waiting for a clock edge; first write after release accepted at w_addr 0.
